lsu_dmem_ctrl: RTL and testbench
================================

Name: lsu_dmem_ctrl

Overview:
Load/store unit between the CPU datapath and the word-addressed data memory (32-bit words, byte address with word index = ADDR[11:2], write on posedge when RW=1, combinational read, RD high-Z while RW=1).
Converts byte, halfword and word load/store requests into word accesses. Sub-word stores use read-modify-write.
Performs little-endian lane selection, sign/zero extension, alignment and range checks, and a request/done handshake so a multi-cycle CPU can stall on it.

Parameters:
ADDR_LIMIT, 1024, byte addresses >= this value are rejected with ERR; no memory access is issued.

Ports:
CLK  in  1  clock; all state changes on posedge.
RST_N  in  1  asynchronous active-low reset.
REQ  in  1  request strobe; sampled only when BUSY=0.
WE  in  1  1=store, 0=load.
SIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
SIGNED  in  1  loads only: 1=sign-extend, 0=zero-extend.
ADDR  in  32  byte address.
WD  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
RD  out  32  load result; valid when DONE=1, held until the next load completes.
BUSY  out  1  high in LOAD, RMW_RD, WRITE.
DONE  out  1  one-cycle completion pulse.
ERR  out  1  valid with DONE: request rejected.
MEM_ADDR  out  32  to memory ADDR: latched address with [1:0]=00.
MEM_RW  out  1  to memory RW.
MEM_WD  out  32  to memory WD.
MEM_RD  in  32  from memory RD.

Behaviour:
- Reset (async, immediate): state=IDLE. RD, MEM_ADDR, MEM_WD = 0. BUSY, DONE, ERR, MEM_RW = 0. A mid-RMW reset aborts with no memory write.
- States: IDLE, LOAD, RMW_RD, WRITE, FIN. DONE=1 only in FIN. MEM_RW=1 only in WRITE.
- Accept: posedge with REQ=1 in IDLE or FIN latches WE, SIZE, SIGNED, ADDR and WD. REQ is ignored while BUSY=1. An accept in FIN allows back-to-back operation.
- Error check at accept: ERR if any of the following; next state is FIN with ERR=1; no memory cycle.
  - SIZE=11.
  - Half with ADDR[0]=1.
  - Word with ADDR[1:0]!=0.
  - ADDR >= ADDR_LIMIT.
  - Otherwise ERR=0 in FIN.
- Load: LOAD (MEM_RW=0) for one cycle. At the end of LOAD, capture MEM_RD, then lane-select and extend into RD. Next state FIN. Latency accept->DONE is 2 cycles.
- Lane select (little-endian): byte offset b=ADDR[1:0] selects MEM_RD[8b+7:8b]. Half at ADDR[1]=0 is [15:0]; ADDR[1]=1 is [31:16].
- Store word: WRITE with MEM_WD=WD. Memory writes at the posedge ending WRITE. Next state FIN. Latency 2.
- Store byte/half: RMW_RD (MEM_RW=0) captures MEM_RD into a merge register with the target lane replaced by WD[7:0] or WD[15:0]. Then WRITE with MEM_WD = merged word, then FIN. Latency 3.
- MEM_ADDR holds the last latched aligned address, including in IDLE and FIN. MEM_WD is don't-care when MEM_RW=0; hold it.
- FIN without a new REQ returns to IDLE. ERR clears on leaving FIN. RD is unchanged by stores and errors.

Test Plan:
- Reset: assert RST_N=0 mid-cycle -> all outputs 0 immediately, MEM_RW=0.
- Word load: mem[1]=9; LW at ADDR=4 -> DONE 2 cycles after accept, RD=0x00000009, ERR=0.
- Sub-word loads: mem[2]=0x80FF7F01.
  - LB at 8 -> RD=0x00000001.
  - LB at 10, SIGNED=1 -> RD=0xFFFFFFFF.
  - LBU at 10 -> RD=0x000000FF.
  - LH at 10, SIGNED=1 -> RD=0xFFFF80FF.
- Byte store RMW: mem[3]=0x11223344; SB at 13 with WD=0xAB -> 3-cycle latency, mem[3]=0x1122AB44. Then SH at 14 with WD=0xBEEF -> mem[3]=0xBEEFAB44.
- Errors -> each gives DONE+ERR 1 cycle after accept, MEM_RW never 1, memory unchanged:
  - LW at 6.
  - SH at 5.
  - SIZE=11.
  - SW at ADDR=1024.
- Handshake:
  - Back-to-back: REQ held through an SW to 0 followed by an LW to 0 -> second request accepted in the FIN cycle, RD=new value.
  - Reset during RMW_RD of an SB -> no write occurs, state returns to IDLE.

Source files
------------

// File: rtl/lsu_dmem_ctrl_if.sv
// CPU-side request/response and memory-side signals of the load/store unit.
// The _i/_o suffixes give the direction as seen from the load/store unit.
interface lsu_dmem_ctrl_if;
  // CPU request
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        sgn_i;
  logic [31:0] addr_i;
  logic [31:0] wd_i;
  // CPU response
  logic [31:0] rd_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  // Data memory side
  logic [31:0] mem_addr_o;
  logic        mem_rw_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  // Environment view: drives requests and memory read data.
  modport master (
    output req_i, we_i, size_i, sgn_i, addr_i, wd_i, mem_rd_i,
    input  rd_o, busy_o, done_o, err_o, mem_addr_o, mem_rw_o, mem_wd_o
  );

  // Load/store unit view.
  modport slave (
    input  req_i, we_i, size_i, sgn_i, addr_i, wd_i, mem_rd_i,
    output rd_o, busy_o, done_o, err_o, mem_addr_o, mem_rw_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit for a word-addressed data memory. Byte/half/word loads
// with little-endian lane select and sign/zero extension; sub-word stores
// by read-modify-write. Misaligned, reserved-size and out-of-range requests
// finish in one cycle with ERR and never touch memory.
module lsu_dmem_ctrl #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  lsu_dmem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [1:0]  off_q, off_d;       // byte offset within the word
  logic [15:0] wd_q, wd_d;         // only the sub-word part is needed after accept
  logic        err_q, err_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;

  logic        accept;
  logic        req_bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  // A request is only sampled when the unit is not busy.
  assign accept = bus.req_i && ((state_q == S_IDLE) || (state_q == S_FIN));

  // Reject reserved size, misalignment and out-of-range addresses.
  always_comb begin
    req_bad = 1'b0;
    if (bus.size_i == 2'b11)                            req_bad = 1'b1;
    if ((bus.size_i == SZ_HALF) && bus.addr_i[0])       req_bad = 1'b1;
    if ((bus.size_i == SZ_WORD) && (bus.addr_i[1:0] != 2'b00)) req_bad = 1'b1;
    if (bus.addr_i >= ADDR_LIMIT)                       req_bad = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; the path of an accepted request is decided at accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (accept) begin
          if (req_bad)                    state_d = S_FIN;
          else if (!bus.we_i)             state_d = S_LOAD;
          else if (bus.size_i == SZ_WORD) state_d = S_WRITE;
          else                            state_d = S_RMW_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:   state_d = S_FIN;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_FIN;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.busy_o   = (state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE);
    bus.done_o   = (state_q == S_FIN);
    bus.mem_rw_o = (state_q == S_WRITE);
  end

  // Little-endian lane selection and extension of the memory read word.
  always_comb begin
    case (off_q)
      2'd0:    lane_b = bus.mem_rd_i[7:0];
      2'd1:    lane_b = bus.mem_rd_i[15:8];
      2'd2:    lane_b = bus.mem_rd_i[23:16];
      default: lane_b = bus.mem_rd_i[31:24];
    endcase
    lane_h = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    case (size_q)
      SZ_BYTE: load_val = {{24{sgn_q & lane_b[7]}}, lane_b};
      SZ_HALF: load_val = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: load_val = bus.mem_rd_i;
    endcase
  end

  // Read word with the target byte/half lane replaced by store data.
  always_comb begin
    merged = bus.mem_rd_i;
    if (size_q == SZ_BYTE) begin
      case (off_q)
        2'd0:    merged[7:0]   = wd_q[7:0];
        2'd1:    merged[15:8]  = wd_q[7:0];
        2'd2:    merged[23:16] = wd_q[7:0];
        default: merged[31:24] = wd_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merged[31:16] = wd_q;
    end else begin
      merged[15:0] = wd_q;
    end
  end

  // Datapath next-state: latch request at accept, capture load/merge data.
  always_comb begin
    size_d     = size_q;
    sgn_d      = sgn_q;
    off_d      = off_q;
    wd_d       = wd_q;
    err_d      = err_q;
    rd_d       = rd_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    if (accept) begin
      size_d     = bus.size_i;
      sgn_d      = bus.sgn_i;
      off_d      = bus.addr_i[1:0];
      wd_d       = bus.wd_i[15:0];
      err_d      = req_bad;
      mem_addr_d = {bus.addr_i[31:2], 2'b00};
      if (bus.we_i && (bus.size_i == SZ_WORD)) mem_wd_d = bus.wd_i;
    end else if (state_q == S_FIN) begin
      err_d = 1'b0;
    end
    if (state_q == S_LOAD)   rd_d     = load_val;
    if (state_q == S_RMW_RD) mem_wd_d = merged;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      off_q      <= 2'b00;
      wd_q       <= 16'h0;
      err_q      <= 1'b0;
      rd_q       <= 32'h0;
      mem_addr_q <= 32'h0;
      mem_wd_q   <= 32'h0;
    end else begin
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      off_q      <= off_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  assign bus.rd_o       = rd_q;
  assign bus.err_o      = err_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_wd_o   = mem_wd_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed table, hand-written
// handshake/reset sequences, then random operations against a word-array model.
module tb_lsu_dmem_ctrl;

  logic clk;
  logic rst_n;

  lsu_dmem_ctrl_if bus();

  lsu_dmem_ctrl #(.ADDR_LIMIT(1024)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge when RW=1.
  // RD would float while writing; it is modelled as zero.
  logic [31:0] mem [0:1023];
  logic        bd_we;
  logic        bd_clear;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;

  assign bus.mem_rd_i = bus.mem_rw_o ? 32'h0 : mem[bus.mem_addr_o[11:2]];

  always @(posedge clk) begin
    if (bus.mem_rw_o)  mem[bus.mem_addr_o[11:2]] <= bus.mem_wd_o;
    else if (bd_clear) for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    else if (bd_we)    mem[bd_idx] <= bd_data;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rd_model;

  int tests;
  int fails;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%08h exp=%08h", name, got, exp);
    end
  endtask

  // Backdoor write to memory and model; starts and ends at a negedge.
  task automatic bd_write(input int idx, input logic [31:0] data);
    bd_idx  = idx[9:0];
    bd_data = data;
    bd_we   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference behaviour computed from the architectural rules.
  task automatic model_op(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic exp_err, output int exp_lat);
    int unsigned idx, sh;
    logic [31:0] w, v, mask;
    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr >= 1024);
    if (exp_err) begin
      exp_lat = 1;
      return;
    end
    idx = addr / 4;
    sh  = 8 * (addr % 4);
    w   = ref_mem[idx];
    if (!we) begin
      exp_lat = 2;
      if (size == 2'd0) begin
        v = (w >> sh) & 32'hFF;
        if (sgn && v >= 128) v = v | 32'hFFFFFF00;
      end else if (size == 2'd1) begin
        v = (w >> sh) & 32'hFFFF;
        if (sgn && v >= 32768) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      rd_model = v;
    end else if (size == 2'd2) begin
      exp_lat = 2;
      ref_mem[idx] = wd;
    end else begin
      exp_lat = 3;
      mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge where DONE is seen.
  task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic got_err, output logic saw_rw);
    bus.req_i  = 1'b1;
    bus.we_i   = we;
    bus.size_i = size;
    bus.sgn_i  = sgn;
    bus.addr_i = addr;
    bus.wd_i   = wd;
    @(posedge clk);
    lat    = 1;
    saw_rw = 1'b0;
    @(negedge clk);
    bus.req_i = 1'b0;
    while (!bus.done_o && lat < 8) begin
      if (bus.mem_rw_o) saw_rw = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    got_err = bus.err_o;
  endtask

  task automatic run_and_check(input string tag, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
    logic exp_err, got_err, saw_rw;
    int   exp_lat, lat;
    model_op(we, size, sgn, addr, wd, exp_err, exp_lat);
    do_op(we, size, sgn, addr, wd, lat, got_err, saw_rw);
    $display("[TB] %s we=%0d size=%0d sgn=%0d addr=%0d wd=%08h -> lat=%0d err=%0d rd=%08h",
             tag, we, size, sgn, addr, wd, lat, got_err, bus.rd_o);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " err"}, {31'b0, got_err}, {31'b0, exp_err});
    check({tag, " rd"}, bus.rd_o, rd_model);
    check({tag, " mem_rw"}, {31'b0, saw_rw}, {31'b0, (we && !exp_err)});
    if (addr < 1024) check({tag, " mem"}, mem[addr[11:2]], ref_mem[addr[11:2]]);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    int          lat;
    logic [31:0] rd;
    int          idx;
    logic [31:0] memv;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int   lat;
    logic got_err, saw_rw;
    tests = 0;
    fails = 0;

    // we, size, sgn, addr, wd, err, lat, rd, mem index, mem value
    vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'd4,    32'h0,      1'b0, 2, 32'h00000009, 1, 32'h00000009};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'd8,    32'h0,      1'b0, 2, 32'h00000001, 2, 32'h80FF7F01};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 32'd10,   32'h0,      1'b0, 2, 32'hFFFFFFFF, 2, 32'h80FF7F01};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'd10,   32'h0,      1'b0, 2, 32'h000000FF, 2, 32'h80FF7F01};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'd10,   32'h0,      1'b0, 2, 32'hFFFF80FF, 2, 32'h80FF7F01};
    vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'd13,   32'hAB,     1'b0, 3, 32'hFFFF80FF, 3, 32'h1122AB44};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'd14,   32'hBEEF,   1'b0, 3, 32'hFFFF80FF, 3, 32'hBEEFAB44};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'd12,   32'h0,      1'b0, 2, 32'hBEEFAB44, 3, 32'hBEEFAB44};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'd6,    32'h0,      1'b1, 1, 32'hBEEFAB44, 1, 32'h00000009};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'd5,    32'h1234,   1'b1, 1, 32'hBEEFAB44, 1, 32'h00000009};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'd0,    32'h0,      1'b1, 1, 32'hBEEFAB44, 0, 32'h00000000};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 32'd1024, 32'hFFFFFFFF, 1'b1, 1, 32'hBEEFAB44, 0, 32'h00000000};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    rd_model   = 32'h0;
    bus.req_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.size_i = 2'b00;
    bus.sgn_i  = 1'b0;
    bus.addr_i = 32'h0;
    bus.wd_i   = 32'h0;
    bd_we      = 1'b0;
    bd_idx     = 10'd0;
    bd_data    = 32'h0;
    bd_clear   = 1'b1;
    rst_n      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bd_clear = 1'b0;

    // Reset state
    check("reset rd", bus.rd_o, 32'h0);
    check("reset mem_addr", bus.mem_addr_o, 32'h0);
    check("reset mem_wd", bus.mem_wd_o, 32'h0);
    check("reset ctl", {28'b0, bus.busy_o, bus.done_o, bus.err_o, bus.mem_rw_o}, 32'h0);
    rst_n = 1'b1;

    bd_write(1, 32'h00000009);
    bd_write(2, 32'h80FF7F01);
    bd_write(3, 32'h11223344);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn,
                    vecs[i].addr, vecs[i].wd);
      check($sformatf("vec%0d tbl_err", i), {31'b0, bus.err_o}, {31'b0, vecs[i].err});
      check($sformatf("vec%0d tbl_rd", i), bus.rd_o, vecs[i].rd);
      check($sformatf("vec%0d tbl_mem", i), mem[vecs[i].idx], vecs[i].memv);
    end

    // Back-to-back: REQ held from an SW to 0 into an LW to 0.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'd2; bus.sgn_i = 1'b0;
    bus.addr_i = 32'd0; bus.wd_i = 32'h5A5A1234;
    @(posedge clk);
    @(negedge clk);
    check("b2b busy in write", {31'b0, bus.busy_o}, 32'h1);
    bus.we_i = 1'b0;           // still requesting; ignored while busy
    @(posedge clk);
    @(negedge clk);
    check("b2b sw done", {31'b0, bus.done_o}, 32'h1);
    check("b2b sw mem", mem[0], 32'h5A5A1234);
    @(posedge clk);            // LW accepted in FIN
    @(negedge clk);
    bus.req_i = 1'b0;
    check("b2b lw busy", {31'b0, bus.busy_o}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("b2b lw done", {31'b0, bus.done_o}, 32'h1);
    check("b2b lw rd", bus.rd_o, 32'h5A5A1234);
    ref_mem[0] = 32'h5A5A1234;
    rd_model   = 32'h5A5A1234;
    $display("[TB] b2b sw/lw addr=0 rd=%08h", bus.rd_o);
    @(negedge clk);

    // Mid-cycle reset during WRITE of an SW: outputs clear immediately, no write.
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'd2; bus.addr_i = 32'd16;
    bus.wd_i = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus.req_i = 1'b0;
    check("rst write phase", {31'b0, bus.mem_rw_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst async rd", bus.rd_o, 32'h0);
    check("rst async mem_addr", bus.mem_addr_o, 32'h0);
    check("rst async mem_wd", bus.mem_wd_o, 32'h0);
    check("rst async ctl", {28'b0, bus.busy_o, bus.done_o, bus.err_o, bus.mem_rw_o}, 32'h0);
    rd_model = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("rst no sw write", mem[4], ref_mem[4]);
    rst_n = 1'b1;
    $display("[TB] reset during SW write, mem[4]=%08h", mem[4]);

    // Reset during RMW_RD of an SB: no write, back to IDLE.
    @(negedge clk);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'd0; bus.addr_i = 32'd13;
    bus.wd_i = 32'h77;
    @(posedge clk);
    @(negedge clk);
    bus.req_i = 1'b0;
    check("rmw busy", {31'b0, bus.busy_o}, 32'h1);
    check("rmw no rw yet", {31'b0, bus.mem_rw_o}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rmw rst busy", {31'b0, bus.busy_o}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rmw rst mem", mem[3], 32'hBEEFAB44);
    $display("[TB] reset during SB rmw, mem[3]=%08h", mem[3]);
    run_and_check("post-rst lw", 1'b0, 2'd2, 1'b0, 32'd12, 32'h0);

    // Random operations against the model.
    for (int n = 0; n < 300; n++) begin
      logic        r_we, r_sgn;
      logic [1:0]  r_size;
      logic [31:0] r_addr, r_wd;
      r_we   = 1'($urandom_range(0, 1));
      r_sgn  = 1'($urandom_range(0, 1));
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1020, 1100))
                                            : 32'($urandom_range(0, 63));
      if (r_size != 2'd3 && $urandom_range(0, 3) != 0)
        r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      r_wd = $urandom;
      run_and_check($sformatf("rnd%0d", n), r_we, r_size, r_sgn, r_addr, r_wd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
